// File: rtl/rotate_fb_reader_pkg.sv
// Shared video definitions for the rotated frame-store reader.
// Holds the line/sync offsets, counter width, the reader FSM state type
// and a saturating counter helper used by the timing generator.
package rotate_fb_reader_pkg;

  // All position and blanking counters share this width.
  localparam int CNT_W = 16;

  // A line is HEIGHT active ticks plus this many blanking ticks.
  localparam int LINE_OFS = 18;

  // hsync covers ticks HEIGHT+HS_START_OFS .. HEIGHT+HS_END_OFS-1.
  localparam int HS_START_OFS = 8;
  localparam int HS_END_OFS   = 10;

  // vsync is raised after vblank line VS_SET_LINE, dropped after VS_CLR_LINE.
  localparam int VS_SET_LINE = 10;
  localparam int VS_CLR_LINE = 12;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FRAME = 2'd1,
    S_VBL   = 2'd2
  } fb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rotate_fb_timing.sv
// Raster timing generator for rotate_fb_reader.
// Owns the xpos/ypos/vbcnt counters, the reader FSM, buffer-swap detection
// and the registered hsync/vsync/vblank/frame_start outputs.
// Ports:
//   clk_i, rst_ni    clock and asynchronous active-low reset
//   ce_i             output pixel enable (one tick)
//   buf_sel_i        buffer the writer is filling
//   xpos_o           current tick position within the line
//   active_o         current line carries picture data
//   swap_o           this tick is a line end with a buffer swap
//   hsync_o, vsync_o, vblank_o, frame_start_o   registered timing outputs
module rotate_fb_timing
  import rotate_fb_reader_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int MARGIN = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic             buf_sel_i,
  output logic [CNT_W-1:0] xpos_o,
  output logic             active_o,
  output logic             swap_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             vblank_o,
  output logic             frame_start_o
);

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(HEIGHT + LINE_OFS - 1);
  localparam logic [CNT_W-1:0] HS_SET   = CNT_W'(HEIGHT + HS_START_OFS);
  localparam logic [CNT_W-1:0] HS_CLR   = CNT_W'(HEIGHT + HS_END_OFS);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(WIDTH + 2 * MARGIN - 1);
  localparam logic [CNT_W-1:0] Y_ACT_LO = CNT_W'(MARGIN);
  localparam logic [CNT_W-1:0] Y_ACT_HI = CNT_W'(WIDTH + MARGIN);
  localparam logic [CNT_W-1:0] VS_SET   = CNT_W'(VS_SET_LINE);
  localparam logic [CNT_W-1:0] VS_CLR   = CNT_W'(VS_CLR_LINE);

  logic [CNT_W-1:0] xpos_q, xpos_d;
  logic [CNT_W-1:0] ypos_q, ypos_d;
  logic [CNT_W-1:0] vbcnt_q, vbcnt_d;
  fb_state_e        state_q, state_d;
  logic             oldBuf_q, oldBuf_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             vblank_q, vblank_d;
  logic             frameStart_q, frameStart_d;

  logic lineEnd;
  logic swap;

  assign lineEnd = ce_i && (xpos_q == X_LAST);
  assign swap    = lineEnd && (buf_sel_i != oldBuf_q);

  // A swap takes priority over every other line-end update, so a frame
  // that is just finishing (or still running) restarts instead of
  // falling into vertical blanking.
  always_comb begin
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    vbcnt_d      = vbcnt_q;
    state_d      = state_q;
    oldBuf_d     = oldBuf_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    vblank_d     = vblank_q;
    frameStart_d = 1'b0;

    if (ce_i) begin
      xpos_d = lineEnd ? '0 : xpos_q + 1'b1;
      if (xpos_q == HS_SET) begin
        hsync_d = 1'b1;
      end else if (xpos_q == HS_CLR) begin
        hsync_d = 1'b0;
      end
    end

    if (lineEnd) begin
      oldBuf_d = buf_sel_i;
      if (swap) begin
        state_d      = S_FRAME;
        ypos_d       = '0;
        vbcnt_d      = '0;
        vsync_d      = 1'b0;
        vblank_d     = 1'b0;
        frameStart_d = 1'b1;
      end else begin
        case (state_q)
          S_FRAME: begin
            if (ypos_q == Y_LAST) begin
              state_d  = S_VBL;
              ypos_d   = '0;
              vbcnt_d  = '0;
              vblank_d = 1'b1;
            end else begin
              ypos_d = ypos_q + 1'b1;
            end
          end
          S_VBL: begin
            if (vbcnt_q == VS_SET) begin
              vsync_d = 1'b1;
            end else if (vbcnt_q == VS_CLR) begin
              vsync_d = 1'b0;
            end
            vbcnt_d = satInc(vbcnt_q);
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xpos_q       <= '0;
      ypos_q       <= '0;
      vbcnt_q      <= '0;
      state_q      <= S_WAIT;
      oldBuf_q     <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      vblank_q     <= 1'b1;
      frameStart_q <= 1'b0;
    end else begin
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      vbcnt_q      <= vbcnt_d;
      state_q      <= state_d;
      oldBuf_q     <= oldBuf_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      vblank_q     <= vblank_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign xpos_o        = xpos_q;
  assign active_o      = (state_q == S_FRAME) && (ypos_q >= Y_ACT_LO) && (ypos_q < Y_ACT_HI);
  assign swap_o        = swap;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign vblank_o      = vblank_q;
  assign frame_start_o = frameStart_q;

endmodule

// File: rtl/rotate_fb_reader.sv
// Read side of the rotated double-buffered frame store.
// Scans the half of the RAM the writer is not filling and regenerates a
// raster of WIDTH lines by HEIGHT pixels with black margin lines.
// Ports:
//   clk, rst_n        video clock and asynchronous active-low reset
//   ce_out            output pixel enable
//   buf_sel           buffer currently being written
//   rd_addr           registered RAM read address
//   rd_data           RAM data, valid one clk after rd_addr
//   video_out         output pixel, 0 on margin lines and in blanking
//   hsync, vsync      sync outputs
//   hblank_out        horizontal blank, aligned with video_out
//   vblank_out        vertical blank
//   frame_start       one-clk pulse when a buffer swap restarts the frame
module rotate_fb_reader
  import rotate_fb_reader_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DEPTH  = 8,
  parameter int MARGIN = 4,
  parameter int AW     = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce_out,
  input  logic             buf_sel,
  output logic [AW-1:0]    rd_addr,
  input  logic [DEPTH-1:0] rd_data,
  output logic [DEPTH-1:0] video_out,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank_out,
  output logic             vblank_out,
  output logic             frame_start
);

  // Buffer 0 occupies the low half of the RAM, buffer 1 the high half.
  localparam logic [AW-1:0]    BUF1_BASE = AW'(WIDTH * HEIGHT);
  localparam logic [CNT_W-1:0] X_ACT     = CNT_W'(HEIGHT);

  logic [CNT_W-1:0] xpos;
  logic             active;
  logic             swap;
  logic             pixTick;

  logic [AW-1:0]    rdAddr_q, rdAddr_d;
  logic [DEPTH-1:0] video_q, video_d;
  logic             hblank_q, hblank_d;
  logic             tickDly_q;
  logic             pixDly_q;
  logic [CNT_W-1:0] xposDly_q, xposDly_d;

  rotate_fb_timing #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .MARGIN (MARGIN)
  ) uTiming (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ce_i          (ce_out),
    .buf_sel_i     (buf_sel),
    .xpos_o        (xpos),
    .active_o      (active),
    .swap_o        (swap),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .vblank_o      (vblank_out),
    .frame_start_o (frame_start)
  );

  assign pixTick = ce_out && active && (xpos < X_ACT);

  // The reader scans the buffer the writer just left, so a swap to
  // buf_sel=1 means the finished picture sits at address 0.
  always_comb begin
    rdAddr_d = rdAddr_q;
    if (swap) begin
      rdAddr_d = buf_sel ? '0 : BUF1_BASE;
    end else if (pixTick) begin
      rdAddr_d = rdAddr_q + 1'b1;
    end
  end

  // Second pipeline stage: one clk after a tick the RAM data for that
  // tick's address is valid, so pixel and hblank are resolved here using
  // the xpos/pixel flags captured at the tick.
  always_comb begin
    video_d   = video_q;
    hblank_d  = hblank_q;
    xposDly_d = ce_out ? xpos : xposDly_q;
    if (tickDly_q) begin
      video_d = pixDly_q ? rd_data : '0;
      if (xposDly_q == '0) begin
        hblank_d = 1'b0;
      end else if (xposDly_q == X_ACT) begin
        hblank_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdAddr_q  <= '0;
      video_q   <= '0;
      hblank_q  <= 1'b1;
      tickDly_q <= 1'b0;
      pixDly_q  <= 1'b0;
      xposDly_q <= '0;
    end else begin
      rdAddr_q  <= rdAddr_d;
      video_q   <= video_d;
      hblank_q  <= hblank_d;
      tickDly_q <= ce_out;
      pixDly_q  <= pixTick;
      xposDly_q <= xposDly_d;
    end
  end

  assign rd_addr    = rdAddr_q;
  assign video_out  = video_q;
  assign hblank_out = hblank_q;

endmodule
